// File: rtl/paillier_task_driver.sv
// paillier_task_driver: host-side initiator for the Paillier accelerator task
// interface. Buffers operands A/B/C, issues one task, streams N K-bit words
// LSW-first and captures the N-word result stream into bank R.
// Optional feature macro: DRV_TIMEOUT_EN adds a WAIT-state watchdog (TIMEOUT).
module paillier_task_driver #(
  parameter int K = 128,
  parameter int N = 32
`ifdef DRV_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 65535
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_bank,
  input  logic [$clog2(N)-1:0]   wr_addr,
  input  logic [K-1:0]           wr_data,
  input  logic [$clog2(N)-1:0]   rd_addr,
  output logic [K-1:0]           rd_data,
  input  logic                   start,
  input  logic [1:0]             cmd,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(N):0]     res_cnt,
  output logic [1:0]             task_cmd,
  output logic                   task_req,
  input  logic                   task_end,
  output logic [K-1:0]           op_a_data,
  output logic                   op_a_valid,
  output logic [K-1:0]           op_b_data,
  output logic                   op_b_valid,
  output logic [K-1:0]           op_c_data,
  output logic                   op_c_valid,
  input  logic [K-1:0]           res_data,
  input  logic                   res_valid
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_STREAM, S_WAIT, S_FLUSH} state_t;

  state_t state, state_nx;

  logic [K-1:0] bank_a [N];
  logic [K-1:0] bank_b [N];
  logic [K-1:0] bank_c [N];
  logic [K-1:0] bank_r [N];

  logic [1:0]    cmd_q;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] widx_nx;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_after;
  logic          start_acc;
  logic          last_word;
  logic          cap_en;
  logic          cap_take;
  logic          cap_drop;
  logic          flush_short;
  logic          timeout_hit;
  logic          err_set;

`ifdef DRV_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tcnt;

  // Watchdog counts WAIT cycles; holding it at zero elsewhere clears it on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= '0;
    else if (state != S_WAIT)  tcnt <= '0;
    else                       tcnt <= tcnt + 16'd1;
  end

  assign timeout_hit = (state == S_WAIT) && !task_end && (tcnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // A start is only taken in IDLE, and a simultaneous abort suppresses it
  assign start_acc   = (state == S_IDLE) && start && !abort;
  assign last_word   = (wcnt == LAST_IDX);
  assign cap_en      = (state != S_IDLE);
  assign cap_take    = cap_en && res_valid && (cnt_q != FULL);
  assign cap_drop    = cap_en && res_valid && (cnt_q == FULL);
  assign cnt_after   = cap_take ? cnt_q + CW'(1) : cnt_q;
  assign flush_short = (state == S_FLUSH) && (cnt_after != FULL);
  assign widx_nx     = (state == S_STREAM) ? wcnt + 1'b1 : '0;

  assign err_set = (wr_en && (state != S_IDLE))
                || cap_drop
                || (task_end && ((state == S_REQ) || (state == S_STREAM)))
                || (abort && (state != S_IDLE))
                || flush_short
                || timeout_hit;

  assign busy     = (state != S_IDLE);
  assign task_req = (state == S_REQ);
  assign task_cmd = (state != S_IDLE) ? cmd_q : 2'b00;
  assign res_cnt  = cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort overrides every non-IDLE transition
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_acc) state_nx = S_REQ;
      S_REQ:    state_nx = S_STREAM;
      S_STREAM: if (last_word) state_nx = S_WAIT;
      S_WAIT: begin
        if (task_end)         state_nx = S_FLUSH;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      S_FLUSH:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // Command latch and word counter; the counter tracks the word now on the buses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= 2'b00;
      wcnt  <= '0;
    end else begin
      if (start_acc) cmd_q <= cmd;
      wcnt <= (state_nx == S_STREAM) ? widx_nx : '0;
    end
  end

  // Operand buses are loaded one cycle ahead so word 0 follows task_req directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_data  <= '0;
      op_b_data  <= '0;
      op_c_data  <= '0;
      op_a_valid <= 1'b0;
      op_b_valid <= 1'b0;
      op_c_valid <= 1'b0;
    end else if (state_nx == S_STREAM) begin
      op_a_data  <= bank_a[widx_nx];
      op_b_data  <= bank_b[widx_nx];
      op_c_data  <= bank_c[widx_nx];
      op_a_valid <= 1'b1;
      op_b_valid <= 1'b1;
      op_c_valid <= !cmd_q[1];
    end else begin
      op_a_data  <= '0;
      op_b_data  <= '0;
      op_c_data  <= '0;
      op_a_valid <= 1'b0;
      op_b_valid <= 1'b0;
      op_c_valid <= 1'b0;
    end
  end

  // Result counter, done pulse and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= (state == S_FLUSH) && !abort;
      if (start_acc)     cnt_q <= '0;
      else if (cap_take) cnt_q <= cnt_q + CW'(1);
      if (start_acc)     err <= 1'b0;
      else if (err_set)  err <= 1'b1;
    end
  end

  // Host writes into operand banks, only while the driver is idle
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      case (wr_bank)
        2'd0:    bank_a[wr_addr] <= wr_data;
        2'd1:    bank_b[wr_addr] <= wr_data;
        2'd2:    bank_c[wr_addr] <= wr_data;
        default: ;
      endcase
    end
  end

  // Result bank capture; words beyond N are dropped
  always_ff @(posedge clk) begin
    if (cap_take) bank_r[cnt_q[AW-1:0]] <= res_data;
  end

  // Registered result read port, live even while a task is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= bank_r[rd_addr];
  end

endmodule

// File: tb/tb_paillier_task_driver.sv
// tb_paillier_task_driver: randomized scoreboard bench for paillier_task_driver.
// Build with DRV_TIMEOUT_EN to exercise the WAIT watchdog at TIMEOUT=100.
`timescale 1ns/1ps
module tb_paillier_task_driver;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = $clog2(N);
`ifdef DRV_TIMEOUT_EN
  localparam int TO = 100;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_bank = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [K-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [K-1:0]  rd_data;
  logic          start = 1'b0;
  logic [1:0]    cmd = '0;
  logic          abort = 1'b0;
  logic          busy, done, err;
  logic [AW:0]   res_cnt;
  logic [1:0]    task_cmd;
  logic          task_req;
  logic          task_end = 1'b0;
  logic [K-1:0]  op_a_data, op_b_data, op_c_data;
  logic          op_a_valid, op_b_valid, op_c_valid;
  logic [K-1:0]  res_data = '0;
  logic          res_valid = 1'b0;

  always #5 clk = ~clk;

  paillier_task_driver #(
    .K(K), .N(N)
`ifdef DRV_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .cmd(cmd), .abort(abort),
    .busy(busy), .done(done), .err(err), .res_cnt(res_cnt),
    .task_cmd(task_cmd), .task_req(task_req), .task_end(task_end),
    .op_a_data(op_a_data), .op_a_valid(op_a_valid),
    .op_b_data(op_b_data), .op_b_valid(op_b_valid),
    .op_c_data(op_c_data), .op_c_valid(op_c_valid),
    .res_data(res_data), .res_valid(res_valid)
  );

  typedef struct {
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] c;
    logic         cv;
    int           idx;
  } word_t;

  word_t expq[$];
  word_t mon_e;

  // Reference model: operand banks, result bank and expected status
  logic [K-1:0] ma [N];
  logic [K-1:0] mb [N];
  logic [K-1:0] mc [N];
  logic [K-1:0] mr [N];
  bit           mr_known [N];
  logic [K-1:0] resp_words [N+2];
  logic         exp_err = 1'b0;
  int           exp_cnt = 0;
  int           exp_done = 0;
  int           exp_req = 0;
  int           done_seen = 0;
  int           req_seen = 0;
  int           age = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic checkOutput(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [K-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: pops the scoreboard whenever an operand word is presented
  always @(negedge clk) begin
    if (rst_n) begin
      if (task_req) begin
        age = 0;
        req_seen++;
      end else begin
        age++;
      end
      if (done) done_seen++;
      if (op_a_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got word %0h expected none", op_a_data);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("op_a_data", op_a_data, mon_e.a);
          checkOutput("op_b_data", op_b_data, mon_e.b);
          checkOutput("op_c_data", op_c_data, mon_e.c);
          checkOutput("op_b_valid", K'(op_b_valid), K'(1));
          checkOutput("op_c_valid", K'(op_c_valid), K'(mon_e.cv));
          checkOutput("word_timing", K'(age), K'(mon_e.idx + 1));
        end
      end else begin
        checkOutput("idle_valids", K'({op_b_valid, op_c_valid}), K'(0));
        checkOutput("idle_buses", op_a_data | op_b_data | op_c_data, K'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hostWrite(input logic [1:0] bank, input int addr, input logic [K-1:0] data);
    wr_en = 1'b1;
    wr_bank = bank;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    case (bank)
      2'd0: ma[addr] = data;
      2'd1: mb[addr] = data;
      2'd2: mc[addr] = data;
      default: ;
    endcase
  endtask

  // Runs one task: c = command, nres = result words returned, abort_word >= 0 aborts
  // while that word is on the buses, wr_busy attempts a host write mid-stream
  task automatic applyStimulus(input logic [1:0] c, input int nres, input int abort_word, input bit wr_busy);
    int sent, cyc, k, nwords;
    bit aborted, ended;
    word_t w;
    nwords = (abort_word >= 0) ? abort_word + 1 : N;
    for (int i = 0; i < nwords; i++) begin
      w.a = ma[i]; w.b = mb[i]; w.c = mc[i]; w.cv = (c[1] == 1'b0); w.idx = i;
      expq.push_back(w);
    end
    start = 1'b1;
    cmd = c;
    tick();
    start = 1'b0;
    exp_req++;
    checkOutput("req_pulse", K'(task_req), K'(1));
    checkOutput("req_cmd", K'(task_cmd), K'(c));
    checkOutput("req_err_cleared", K'(err), K'(0));
    checkOutput("req_res_cnt", K'(res_cnt), K'(0));
    sent = 0; cyc = 0; aborted = 1'b0; ended = 1'b0;
    while (!aborted && !ended && cyc < 400) begin
      if (abort_word >= 0 && cyc == abort_word + 1) begin
        abort = 1'b1;
      end else if (sent < nres && $urandom_range(0, 3) != 0) begin
        res_valid = 1'b1;
        res_data = resp_words[sent];
        sent++;
      end else if (sent == nres && cyc >= N + 1 && abort_word < 0) begin
        task_end = 1'b1;
      end
      if (wr_busy && cyc == 5) begin
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = AW'(3); wr_data = ~ma[3];
      end
      if (cyc == 7) begin
        start = 1'b1; cmd = ~c;
      end
      aborted = abort;
      ended = task_end;
      tick();
      abort = 1'b0; res_valid = 1'b0; task_end = 1'b0; wr_en = 1'b0; start = 1'b0;
      cyc++;
      if (cyc == 8 && !aborted) checkOutput("task_cmd_held", K'(task_cmd), K'(c));
    end
    if (ended) begin
      checkOutput("flush_busy", K'(busy), K'(1));
      checkOutput("flush_no_done", K'(done), K'(0));
      tick();
      checkOutput("done_pulse", K'(done), K'(1));
      checkOutput("done_idle", K'(busy), K'(0));
      exp_done++;
      k = (nres < N) ? nres : N;
      for (int i = 0; i < k; i++) begin mr[i] = resp_words[i]; mr_known[i] = 1'b1; end
      exp_cnt = k;
      exp_err = (nres != N) || wr_busy;
      tick();
      checkOutput("done_width", K'(done), K'(0));
    end else if (aborted) begin
      checkOutput("abort_busy", K'(busy), K'(0));
      checkOutput("abort_valids", K'({op_a_valid, op_b_valid, op_c_valid}), K'(0));
      checkOutput("abort_task", K'({task_req, task_cmd}), K'(0));
      checkOutput("abort_err", K'(err), K'(1));
      k = (sent < N) ? sent : N;
      for (int i = 0; i < k; i++) begin mr[i] = resp_words[i]; mr_known[i] = 1'b1; end
      exp_cnt = k;
      exp_err = 1'b1;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL task_bound: got no completion expected completion within 400 cycles");
    end
  endtask

  // Compares status, pulse counts and the whole result bank against the model
  task automatic verifyState();
    @(negedge clk);
    checkOutput("scoreboard_drained", K'(expq.size()), K'(0));
    checkOutput("res_cnt", K'(res_cnt), K'(exp_cnt));
    checkOutput("err", K'(err), K'(exp_err));
    checkOutput("done_count", K'(done_seen), K'(exp_done));
    checkOutput("req_count", K'(req_seen), K'(exp_req));
    tick();
    for (int i = 0; i < N; i++) begin
      if (mr_known[i]) begin
        rd_addr = AW'(i);
        tick();
        checkOutput($sformatf("rd_data[%0d]", i), rd_data, mr[i]);
      end
    end
  endtask

  // Decryption-style task that never gets task_end
  task automatic runNoEnd();
    word_t w;
    for (int i = 0; i < N; i++) begin
      w.a = ma[i]; w.b = mb[i]; w.c = mc[i]; w.cv = 1'b1; w.idx = i;
      expq.push_back(w);
    end
    start = 1'b1;
    cmd = 2'b01;
    tick();
    start = 1'b0;
    exp_req++;
`ifdef DRV_TIMEOUT_EN
    repeat (N + TO) tick();
    checkOutput("wait_before_timeout", K'(busy), K'(1));
    tick();
    checkOutput("timeout_idle", K'(busy), K'(0));
    checkOutput("timeout_err", K'(err), K'(1));
    checkOutput("timeout_no_done", K'(done), K'(0));
`else
    repeat (1000) tick();
    checkOutput("still_waiting", K'(busy), K'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_from_wait", K'(busy), K'(0));
`endif
    exp_err = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int aw, nr;
    logic [1:0] c;
    for (int i = 0; i < N; i++) mr_known[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_status", K'({busy, done, err, task_req, task_cmd}), K'(0));
    checkOutput("rst_res_cnt", K'(res_cnt), K'(0));
    checkOutput("rst_valids", K'({op_a_valid, op_b_valid, op_c_valid}), K'(0));
    checkOutput("rst_buses", op_a_data | op_b_data | op_c_data, K'(0));
    checkOutput("rst_rd_data", rd_data, K'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) begin
      hostWrite(2'd0, i, K'(i + 1));
      hostWrite(2'd1, i, K'(32'h100 + i));
      hostWrite(2'd2, i, K'(32'hFFFF - i));
    end

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b00, N, -1, 1'b0);
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = K'(32'hA0 + i);
    applyStimulus(2'b10, N, -1, 1'b0);
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b11, N + 1, -1, 1'b0);
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b10, N, 10, 1'b0);
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b00, N, -1, 1'b0);
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b11, N, -1, 1'b1);
    verifyState();

    start = 1'b1; abort = 1'b1; cmd = 2'b01;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_beats_start", K'({busy, task_req}), K'(0));
    verifyState();

    for (int t = 0; t < 5; t++) begin
      repeat (6) hostWrite(2'($urandom_range(0, 3)), $urandom_range(0, N - 1), rnd128());
      for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
      c = 2'($urandom_range(0, 3));
      nr = $urandom_range(N - 2, N + 1);
      aw = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : -1;
      applyStimulus(c, nr, aw, 1'b0);
      verifyState();
    end

    runNoEnd();
    verifyState();

    for (int i = 0; i < N; i++) begin
      word_t w;
      w.a = ma[i]; w.b = mb[i]; w.c = mc[i]; w.cv = 1'b1; w.idx = i;
      expq.push_back(w);
    end
    start = 1'b1; cmd = 2'b00;
    tick();
    start = 1'b0;
    exp_req++;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_status", K'({busy, done, err, task_req, task_cmd}), K'(0));
    checkOutput("async_rst_valids", K'({op_a_valid, op_b_valid, op_c_valid}), K'(0));
    checkOutput("async_rst_res_cnt", K'(res_cnt), K'(0));
    expq.delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    verifyState();

    for (int i = 0; i < N + 2; i++) resp_words[i] = rnd128();
    applyStimulus(2'b01, N, -1, 1'b0);
    verifyState();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
